// File: rtl/hpb_wr_ctl.sv
// Host write initiator for the strategy symbol RAM: buffers host writes in a small FIFO and
// issues them one at a time as req/drop handshakes. Optional timeout abort: HPB_WR_TIMEOUT_EN.
module hpb_wr_ctl #(
    parameter int unsigned RAM_WIDTH      = 64,
    parameter int unsigned WR_EN_W        = RAM_WIDTH / 8,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 host_wr_valid,
    output logic                 host_wr_ready,
    input  logic [13:0]          host_wr_addr,
    input  logic [RAM_WIDTH-1:0] host_wr_data,
    input  logic [WR_EN_W-1:0]   host_wr_be,
    output logic [13:0]          hpb_wr_addr,
    output logic [RAM_WIDTH-1:0] hpb_wr_data,
    output logic [WR_EN_W-1:0]   hpb_wr_en,
    output logic                 hpb_wr_req,
    input  logic                 rcb_wr_done,
    input  logic                 err_clr,
    output logic                 hpb_busy,
    output logic                 hpb_err,
    output logic [15:0]          hpb_wr_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
    state_t state;

    logic [13:0]          fifo_addr [FIFO_DEPTH];
    logic [RAM_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [WR_EN_W-1:0]   fifo_be   [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic                 full, empty, push, pop, tmo_hit;

    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty         = (wr_ptr == rd_ptr);
    assign host_wr_ready = !full;
    assign push          = host_wr_valid && !full;
    assign pop           = !empty && (state == IDLE || state == DROP);
    assign hpb_busy      = !empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[AW-1:0]] <= host_wr_addr;
            fifo_data[wr_ptr[AW-1:0]] <= host_wr_data;
            fifo_be[wr_ptr[AW-1:0]]   <= host_wr_be;
        end
    end

`ifdef HPB_WR_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Held at zero outside REQ, so it reads zero in the first REQ cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            hpb_err <= 1'b0;
        end else begin
            tmo_cnt <= (state == REQ) ? tmo_cnt + TW'(1) : '0;
            if (state == REQ && !rcb_wr_done && tmo_hit)
                hpb_err <= 1'b1;
            else if (err_clr)
                hpb_err <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign tmo_hit    = 1'b0;
    assign hpb_err    = 1'b0;
    assign unused_cfg = err_clr ^ (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            hpb_wr_req   <= 1'b0;
            hpb_wr_addr  <= '0;
            hpb_wr_data  <= '0;
            hpb_wr_en    <= '0;
            hpb_wr_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case (state)
                IDLE, DROP: begin
                    if (!empty) begin
                        hpb_wr_addr <= fifo_addr[rd_ptr[AW-1:0]];
                        hpb_wr_data <= fifo_data[rd_ptr[AW-1:0]];
                        hpb_wr_en   <= fifo_be[rd_ptr[AW-1:0]];
                        hpb_wr_req  <= 1'b1;
                        state       <= REQ;
                    end else begin
                        hpb_wr_req  <= 1'b0;
                        state       <= IDLE;
                    end
                end
                REQ: begin
                    if (rcb_wr_done) begin
                        hpb_wr_count <= hpb_wr_count + 16'd1;
                        hpb_wr_req   <= 1'b0;
                        state        <= DROP;
                    end else if (tmo_hit) begin
                        hpb_wr_req   <= 1'b0;
                        state        <= DROP;
                    end
                end
                default: begin
                    hpb_wr_req <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule
